cascade_stage_ctrl: RTL

- Sequences the cascade classifier's stage loop for one detection window.
- Issues a per-stage start to the feature-accumulation engine and fetches that stage's threshold from the stage threshold ROM (1-cycle synchronous read).
- Compares the accumulated stage sum against the threshold and either advances to the next stage or ends with reject/detect.
- Sits between the window scheduler (start/done) and the feature engine + threshold ROM.

---
 rtl/cascade_stage_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/cascade_stage_ctrl.sv
// -----------------------------------------------------------------------------
// cascade_stage_ctrl
//
// Sequences the stage loop of the cascade classifier for one detection window.
// For every stage it pulses stage_start to the feature-accumulation engine,
// reads the stage threshold from a synchronous ROM (1-cycle latency), then
// waits for the accumulated stage sum. The window either advances to the next
// stage (sum >= threshold), ends with detect (last stage passed) or ends with
// reject (any stage failed).
//
// Optional build macro: CASCADE_STAGE_CTRL_ABORT_EN
//   When defined, adds the 'abort' input. abort=1 in any non-IDLE state
//   returns the controller to IDLE on the next edge, without a done pulse,
//   and leaves detect/exit_stage untouched.
//
// Ports:
//   clk              clock
//   rst              asynchronous, active-high reset
//   start            begin a window (sampled only in IDLE)
//   abort            (macro only) cancel the current window
//   busy             high in every state except IDLE
//   stage_start      1-cycle pulse: feature engine starts stage stage_idx
//   stage_idx        current stage index
//   stage_sum        signed accumulated stage sum
//   stage_sum_valid  stage_sum valid
//   stage_sum_ready  controller accepts stage_sum (WAIT state)
//   rom_en           threshold ROM read enable
//   rom_addr         threshold ROM address
//   rom_data         signed threshold, valid the cycle after rom_en
//   done             1-cycle pulse: verdict final
//   detect           1 = window passed every stage (held until next start)
//   exit_stage       stage where evaluation ended (held until next start)
// -----------------------------------------------------------------------------
module cascade_stage_ctrl #(
    parameter int W_DATA   = 11,
    parameter int W_ADDR   = 5,
    parameter int N_STAGES = 25,
    parameter int W_SUM    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
`ifdef CASCADE_STAGE_CTRL_ABORT_EN
    input  logic              abort,
`endif
    output logic              busy,
    output logic              stage_start,
    output logic [W_ADDR-1:0] stage_idx,
    input  logic [W_SUM-1:0]  stage_sum,
    input  logic              stage_sum_valid,
    output logic              stage_sum_ready,
    output logic              rom_en,
    output logic [W_ADDR-1:0] rom_addr,
    input  logic [W_DATA-1:0] rom_data,
    output logic              done,
    output logic              detect,
    output logic [W_ADDR-1:0] exit_stage
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STAGE,
        S_LOAD,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [W_ADDR-1:0] LAST_STAGE = W_ADDR'(N_STAGES - 1);

    // Signed compare at the stage-sum width; the threshold is sign-extended
    // so a negative threshold stays negative. Equality counts as a pass.
    function automatic logic stage_passes(input logic signed [W_SUM-1:0]  sum,
                                          input logic signed [W_DATA-1:0] thr);
        logic signed [W_SUM-1:0] thr_ext;
        thr_ext = W_SUM'(thr);
        return (sum >= thr_ext);
    endfunction

    state_t                    state_q, state_d;
    logic [W_ADDR-1:0]         idx_q, idx_d;
    logic signed [W_DATA-1:0]  thr_q, thr_d;
    logic                      det_q, det_d;
    logic [W_ADDR-1:0]         exit_q, exit_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            thr_q   <= '0;
            det_q   <= 1'b0;
            exit_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            thr_q   <= thr_d;
            det_q   <= det_d;
            exit_q  <= exit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        thr_d   = thr_q;
        det_d   = det_q;
        exit_d  = exit_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_STAGE;
                    idx_d   = '0;
                    det_d   = 1'b0;
                    exit_d  = '0;
                end
            end
            S_STAGE: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                // ROM data for the address issued in STAGE is valid now.
                thr_d   = $signed(rom_data);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (stage_sum_valid) begin
                    if (stage_passes($signed(stage_sum), thr_q)) begin
                        if (idx_q == LAST_STAGE) begin
                            det_d   = 1'b1;
                            exit_d  = idx_q;
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + W_ADDR'(1);
                            state_d = S_STAGE;
                        end
                    end else begin
                        det_d   = 1'b0;
                        exit_d  = idx_q;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef CASCADE_STAGE_CTRL_ABORT_EN
        // Abort overrides anything decided above, including a same-cycle
        // stage_sum handshake; the previous verdict outputs are preserved.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            idx_d   = '0;
            thr_d   = thr_q;
            det_d   = det_q;
            exit_d  = exit_q;
        end
`endif
    end

    // All outputs decode from registered state only.
    assign busy            = (state_q != S_IDLE);
    assign stage_start     = (state_q == S_STAGE);
    assign rom_en          = (state_q == S_STAGE);
    assign rom_addr        = idx_q;
    assign stage_idx       = idx_q;
    assign stage_sum_ready = (state_q == S_WAIT);
    assign done            = (state_q == S_DONE);
    assign detect          = det_q;
    assign exit_stage      = exit_q;

endmodule
